hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It drives stall and flush on the F/D, D/E, E/M and M/W pipeline registers, and on the PC register.
- Arbitrates between several hazard sources: icache miss, dcache miss, multi-cycle MDU, load-use, E-stage branch redirect, and M-stage exception/eret.
- Remembers flush requests that arrive while the pipe is frozen, so no wrong-path instruction survives a stall.

---
 rtl/mips_pipe_pkg.sv | 52 +++++
 rtl/hazard_perf_cnt.sv | 39 +++
 rtl/hazard_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared types and constants for the 5-stage MIPS pipeline control path.
//   hazard_state_t : states of the central hazard controller
//   STAGE_CNT      : number of pipeline registers that can be stalled (PC..M/W)
//   STG_*          : index of each stage inside a pipe_ctrl_t bundle
//   pipe_ctrl_t    : stall[4:0] for F,D,E,M,W and flush[4:1] for D,E,M,W, so a
//                    pipeline-register module can take one bundle
// Optional build macro used by the consumers of this package:
//   HAZARD_PERF_CNT_EN adds performance counters to hazard_ctrl.
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    EXC_HOLD = 2'd2
  } hazard_state_t;

  localparam int STAGE_CNT = 5;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int PERF_CNT_N = 3;
  localparam int PERF_CNT_W = 32;

  typedef struct packed {
    logic [STAGE_CNT-1:0] stall;
    logic [STAGE_CNT-1:1] flush;
  } pipe_ctrl_t;

  // Nothing held, nothing cleared: the normal free-running pipe.
  function automatic pipe_ctrl_t pipe_ctrl_idle();
    pipe_ctrl_t c;
    c.stall = '0;
    c.flush = '0;
    return c;
  endfunction

  // Reset view: every pipeline register past the PC is cleared, nothing held.
  function automatic pipe_ctrl_t pipe_ctrl_reset();
    pipe_ctrl_t c;
    c.stall = '0;
    c.flush = '1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt
// Bank of N independent saturating event counters.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears every counter
//   inc  : one increment strobe per counter, sampled each clock
//   cnt  : current counter values, cnt[k] belongs to inc[k]
// Counters stick at all-ones instead of wrapping so a long run never reads
// as a small number.
// -----------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        inc,
  output logic [N-1:0][W-1:0] cnt
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cnt
      logic [W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (inc[gi] && (cnt_reg != {W{1'b1}})) begin
          cnt_reg <= cnt_reg + {{(W-1){1'b0}}, 1'b1};
        end
      end

      assign cnt[gi] = cnt_reg;
    end
  endgenerate

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central stall/flush controller for the 5-stage MIPS pipeline. Arbitrates
// icache miss, dcache miss, multi-cycle MDU, load-use, E-stage redirect and
// M-stage exception/eret, and remembers a redirect that arrives while the pipe
// is frozen so the wrong-path instruction in D is still killed on release.
//
// Parameters:
//   MDU_TIMEOUT : max cycles in MDU_WAIT before a forced exit with mdu_cancel
//                 (0 disables the timeout)
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_stall, d_stall               : icache / dcache miss
//   mdu_start, mdu_done            : MDU issue pulse in E / MDU result valid
//   load_use                       : E-stage load feeds a D-stage consumer
//   redirectE                      : E-stage redirect, wrong-path instr in D
//   exceptM, eretM                 : exception / eret committed in M
//   stallF..stallW                 : hold PC, F/D, D/E, E/M, M/W registers
//   flushD..flushW                 : clear F/D, D/E, E/M, M/W registers
//   mdu_cancel                     : abort the in-flight MDU operation
//   stall_cycles, flush_events,
//   mdu_wait_cycles                : perf counters, only with HAZARD_PERF_CNT_EN
//
// All outputs are combinational from state, pending-flush flag and inputs.
// Build macro: HAZARD_PERF_CNT_EN adds the three saturating perf counters.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        d_stall,
  input  logic        mdu_start,
  input  logic        mdu_done,
  input  logic        load_use,
  input  logic        redirectE,
  input  logic        exceptM,
  input  logic        eretM,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        stallW,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        mdu_cancel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] mdu_wait_cycles
`endif
);

  hazard_state_t state_reg, state_next;
  logic          pend_d_reg, pend_d_next;
  logic [31:0]   mdu_cnt_reg, mdu_cnt_next;

  pipe_ctrl_t    ctrl;
  logic          cancel;
  logic          exc;
  logic          ls;
  logic          kill_d;
  logic          timeout_hit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      pend_d_reg  <= 1'b0;
      mdu_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pend_d_reg  <= pend_d_next;
      mdu_cnt_reg <= mdu_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs, rules evaluated in priority order
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl         = pipe_ctrl_idle();
    cancel       = 1'b0;
    state_next   = state_reg;
    pend_d_next  = pend_d_reg;
    mdu_cnt_next = mdu_cnt_reg;
    kill_d       = 1'b0;

    exc = exceptM | eretM;
    ls  = i_stall | d_stall | ((state_reg == MDU_WAIT) & ~mdu_done);

    // The counter holds the number of MDU_WAIT cycles already completed, so
    // this fires on the MDU_TIMEOUT-th waiting cycle. A done in that same
    // cycle is a normal completion and wins.
    timeout_hit = (MDU_TIMEOUT != 0) && (state_reg == MDU_WAIT) && !mdu_done &&
                  (mdu_cnt_reg == 32'(MDU_TIMEOUT - 1));

    if (exc) begin
      // Everything younger than the committing instruction is wrong-path.
      // The PC still waits on a pending fetch so the vector fetch is not lost.
      ctrl.flush         = '1;
      ctrl.stall[STG_F]  = i_stall;
      cancel             = (state_reg == MDU_WAIT) | mdu_start;
      pend_d_next        = 1'b0;
      mdu_cnt_next       = '0;
      state_next         = i_stall ? EXC_HOLD : RUN;
    end else if (state_reg == EXC_HOLD) begin
      // Keep D empty until fetch delivers; the exit cycle still flushes D
      // because the fetched word in flight belongs to the old path.
      ctrl.stall[STG_F] = 1'b1;
      ctrl.flush[STG_D] = 1'b1;
      if (!i_stall) begin
        state_next = RUN;
      end
    end else begin
      if (ls) begin
        ctrl.stall = '1;
        // During an MDU wait the older M/W instructions keep draining while
        // the MDU instruction sits in E; a bubble enters M behind them.
        // A dcache miss freezes M/W regardless.
        if ((state_reg == MDU_WAIT) && !d_stall) begin
          ctrl.stall[STG_M] = 1'b0;
          ctrl.stall[STG_W] = 1'b0;
          ctrl.flush[STG_M] = 1'b1;
        end
        // D cannot be flushed while held; remember it for the release cycle.
        if (redirectE) begin
          pend_d_next = 1'b1;
        end
      end else begin
        kill_d            = redirectE | pend_d_reg;
        ctrl.flush[STG_D] = kill_d;
        pend_d_next       = 1'b0;
        // A killed D instruction has no consumer to protect.
        if (!kill_d && load_use) begin
          ctrl.stall[STG_F] = 1'b1;
          ctrl.stall[STG_D] = 1'b1;
          ctrl.flush[STG_E] = 1'b1;
        end
      end

      case (state_reg)
        RUN: begin
          // start+done together is a single-cycle operation
          if (mdu_start && !mdu_done) begin
            state_next   = MDU_WAIT;
            mdu_cnt_next = '0;
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state_next   = RUN;
            mdu_cnt_next = '0;
          end else if (timeout_hit) begin
            cancel       = 1'b1;
            state_next   = RUN;
            mdu_cnt_next = '0;
          end else if (mdu_cnt_reg != 32'hFFFF_FFFF) begin
            mdu_cnt_next = mdu_cnt_reg + 32'd1;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end

    // Reset view overrides everything for as long as rst is held.
    if (rst) begin
      ctrl   = pipe_ctrl_reset();
      cancel = 1'b0;
    end
  end

  assign stallF     = ctrl.stall[STG_F];
  assign stallD     = ctrl.stall[STG_D];
  assign stallE     = ctrl.stall[STG_E];
  assign stallM     = ctrl.stall[STG_M];
  assign stallW     = ctrl.stall[STG_W];
  assign flushD     = ctrl.flush[STG_D];
  assign flushE     = ctrl.flush[STG_E];
  assign flushM     = ctrl.flush[STG_M];
  assign flushW     = ctrl.flush[STG_W];
  assign mdu_cancel = cancel;

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters: not touched by exceptions, only by rst
  // ---------------------------------------------------------------------------
  logic [PERF_CNT_N-1:0]                 perf_inc;
  logic [PERF_CNT_N-1:0][PERF_CNT_W-1:0] perf_cnt;

  assign perf_inc = {(state_reg == MDU_WAIT), ctrl.flush[STG_D], ctrl.stall[STG_F]};

  hazard_perf_cnt #(
    .N (PERF_CNT_N),
    .W (PERF_CNT_W)
  ) u_perf (
    .clk (clk),
    .rst (rst),
    .inc (perf_inc),
    .cnt (perf_cnt)
  );

  assign stall_cycles    = perf_cnt[0];
  assign flush_events    = perf_cnt[1];
  assign mdu_wait_cycles = perf_cnt[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Scoreboard bench for hazard_ctrl. The driver applies one input vector per
// cycle on the falling edge, evaluates the hazard rules on its own abstract
// pipeline model and queues the expected outputs; an independent monitor pops
// one entry per cycle and compares it against the DUT outputs.
// Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_stall = 1'b0, d_stall = 1'b0, mdu_start = 1'b0, mdu_done = 1'b0;
  logic load_use = 1'b0, redirectE = 1'b0, exceptM = 1'b0, eretM = 1'b0;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushD, flushE, flushM, flushW, mdu_cancel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, mdu_wait_cycles;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_stall    (i_stall),
    .d_stall    (d_stall),
    .mdu_start  (mdu_start),
    .mdu_done   (mdu_done),
    .load_use   (load_use),
    .redirectE  (redirectE),
    .exceptM    (exceptM),
    .eretM      (eretM),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .stallM     (stallM),
    .stallW     (stallW),
    .flushD     (flushD),
    .flushE     (flushE),
    .flushM     (flushM),
    .flushW     (flushW),
    .mdu_cancel (mdu_cancel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .mdu_wait_cycles (mdu_wait_cycles)
`endif
  );

  typedef struct {
    int         cyc;
    string      tag;
    bit         in_rst;
    logic [9:0] outs;   // {sF,sD,sE,sM,sW,fD,fE,fM,fW,cancel}
`ifdef HAZARD_PERF_CNT_EN
    longint     p_stall;
    longint     p_flush;
    longint     p_mdu;
`endif
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Abstract model: where the pipe is (0 free, 1 waiting on MDU, 2 holding
  // after an exception), whether D owes a kill, and how many MDU cycles waited.
  int     m_mode   = 0;
  bit     m_pend   = 1'b0;
  int     m_waited = 0;
  longint m_c_stall = 0, m_c_flush = 0, m_c_mdu = 0;

  task automatic step(input string tag, input bit r, input bit i, input bit d,
                      input bit ms, input bit md, input bit lu, input bit re,
                      input bit ex, input bit er);
    bit sF, sD, sE, sM, sW, fD, fE, fM, fW, cn, ls;
    int nmode, nwait;
    bit npend;
    exp_t e;
    @(negedge clk);
    rst = r; i_stall = i; d_stall = d; mdu_start = ms; mdu_done = md;
    load_use = lu; redirectE = re; exceptM = ex; eretM = er;

    {sF, sD, sE, sM, sW, fD, fE, fM, fW, cn} = '0;
    nmode = m_mode; npend = m_pend; nwait = m_waited;

    if (r) begin
      {fD, fE, fM, fW} = 4'b1111;
      nmode = 0; npend = 1'b0; nwait = 0;
    end else if (ex || er) begin
      {fD, fE, fM, fW} = 4'b1111;
      sF    = i;
      cn    = (m_mode == 1) || ms;
      npend = 1'b0;
      nmode = i ? 2 : 0;
      nwait = 0;
    end else if (m_mode == 2) begin
      sF = 1'b1; fD = 1'b1;
      nmode = i ? 2 : 0;
    end else begin
      ls = i || d || (m_mode == 1 && !md);
      if (ls) begin
        {sF, sD, sE, sM, sW} = 5'b11111;
        if (m_mode == 1 && !d) begin
          sM = 1'b0; sW = 1'b0; fM = 1'b1;
        end
        if (re) npend = 1'b1;
      end else begin
        if (re || m_pend) fD = 1'b1;
        else if (lu) begin
          sF = 1'b1; sD = 1'b1; fE = 1'b1;
        end
        npend = 1'b0;
      end
      if (m_mode == 0 && ms && !md) begin
        nmode = 1; nwait = 0;
      end else if (m_mode == 1) begin
        if (md) nmode = 0;
        else if (m_waited + 1 == TO) begin
          cn = 1'b1; nmode = 0; nwait = 0;
        end else nwait = m_waited + 1;
      end
    end

    e.cyc    = cyc;
    e.tag    = tag;
    e.in_rst = r;
    e.outs   = {sF, sD, sE, sM, sW, fD, fE, fM, fW, cn};
`ifdef HAZARD_PERF_CNT_EN
    e.p_stall = m_c_stall;
    e.p_flush = m_c_flush;
    e.p_mdu   = m_c_mdu;
`endif
    sb_q.push_back(e);

    if (r) begin
      m_c_stall = 0; m_c_flush = 0; m_c_mdu = 0;
    end else begin
      m_c_stall += longint'(sF);
      m_c_flush += longint'(fD);
      m_c_mdu   += (m_mode == 1) ? 1 : 0;
    end
    m_mode = nmode; m_pend = npend; m_waited = nwait;
    cyc++;
  endtask

  // Monitor: one popped entry per cycle, sampled mid-low-phase.
  initial begin
    exp_t e;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = {stallF, stallD, stallE, stallM, stallW,
               flushD, flushE, flushM, flushW, mdu_cancel};
        n_cmp++;
        if (got !== e.outs) begin
          n_fail++;
          $display("FAIL %s cyc=%0d outs got=%b exp=%b", e.tag, e.cyc, got, e.outs);
        end else begin
          $display("cyc=%0d %s outs=%b ok", e.cyc, e.tag, got);
        end
`ifdef HAZARD_PERF_CNT_EN
        if (!e.in_rst) begin
          n_cmp++;
          if ({32'(stall_cycles), 32'(flush_events), 32'(mdu_wait_cycles)} !==
              {32'(e.p_stall), 32'(e.p_flush), 32'(e.p_mdu)}) begin
            n_fail++;
            $display("FAIL %s_perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", e.tag, e.cyc,
                     stall_cycles, flush_events, mdu_wait_cycles, e.p_stall, e.p_flush, e.p_mdu);
          end
        end
`endif
      end
    end
  end

  initial begin
    //              tag        r  i  d  ms md lu re ex er
    step("reset",   1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset",   1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle",    0, 0, 0, 0, 0, 0, 0, 0, 0);

    // load-use for exactly one cycle
    step("lu",      0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("lu_after",0, 0, 0, 0, 0, 0, 0, 0, 0);

    // redirect during a 4-cycle dcache miss, killed once on release
    step("dmiss",   0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("dmiss_re",0, 0, 1, 0, 0, 0, 1, 0, 0);
    step("dmiss",   0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("dmiss",   0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("dm_rel",  0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("dm_after",0, 0, 0, 0, 0, 0, 0, 0, 0);

    // MDU with done 8 cycles after start
    step("mdu_go",  0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step("mdu_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mdu_done",0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("mdu_aft", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // exception in the 3rd MDU_WAIT cycle with an icache miss outstanding
    step("exc_go",  0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("exc_w",   0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("exc_w",   0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("exc",     0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) step("exc_hold", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("exc_rel", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("exc_aft", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // timeout: done never arrives
    step("to_go",   0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < TO + 2; k++) step("to_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of a stall with a pending D kill
    step("rs_dm",   0, 0, 1, 0, 0, 0, 1, 0, 0);
    step("rs_dm",   0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("rs_rst",  1, 0, 1, 0, 0, 0, 0, 0, 0);
    step("rs_rst",  1, 0, 1, 0, 0, 0, 0, 0, 0);
    step("rs_aft",  0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rs_aft",  0, 0, 0, 0, 0, 0, 0, 0, 0);

    // eret while idle, no fetch miss
    step("eret",    0, 0, 0, 0, 0, 0, 1, 0, 1);
    step("eret_aft",0, 0, 0, 0, 0, 1, 0, 0, 0);

    for (int k = 0; k < 1500; k++) begin
      step("rand",
           ($urandom_range(299) == 0),
           ($urandom_range(4) == 0),
           ($urandom_range(5) == 0),
           ($urandom_range(9) == 0),
           ($urandom_range(11) == 0),
           ($urandom_range(5) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(39) == 0),
           ($urandom_range(59) == 0));
    end

    @(negedge clk);
    #4;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain left=%0d exp=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
